// File: rtl/gpu_pkg.sv
// Shared definitions for the host-data ingress path: loader FSM states,
// header opcode values and header field positions.
package gpu_pkg;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    DATA    = 2'd1,
    DISCARD = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

  localparam logic [3:0] OPC_WRITE = 4'hA;
  localparam int         OPC_MSB   = 31;
  localparam int         OPC_LSB   = 28;

  function automatic logic [3:0] hdr_opcode(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/axis_mem_loader_if.sv
// Stream-in / memory-write-out bundle of axis_mem_loader.
// slave = loader view, master = host + memory side.
interface axis_mem_loader_if #(
  parameter int ADDR_W = 12
);
  logic [31:0]       axis_tdata;
  logic [3:0]        axis_tkeep;
  logic              axis_tlast;
  logic              axis_tvalid;
  logic              axis_tready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_wr_en;
  logic              mem_wr_ready;

  modport slave (
    input  axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
    output axis_tready,
    output mem_addr, mem_wr_data, mem_wr_en,
    input  mem_wr_ready
  );

  modport master (
    output axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
    input  axis_tready,
    input  mem_addr, mem_wr_data, mem_wr_en,
    output mem_wr_ready
  );
endinterface

// File: rtl/axis_wr_slot.sv
// Single-entry write register toward data memory. A new entry may be loaded
// whenever the slot is empty or its current request retires this cycle.
module axis_wr_slot #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [3:0]        load_keep,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_en,
  output logic              can_accept
);

  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       data_reg;
  logic [3:0]        en_reg;

  // A load with zero keep leaves the slot empty: the beat occupies no write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      data_reg <= '0;
      en_reg   <= '0;
    end else if (load) begin
      addr_reg <= load_addr;
      data_reg <= load_data;
      en_reg   <= load_keep;
    end else if (wr_ready) begin
      en_reg   <= '0;
    end
  end

  assign addr       = addr_reg;
  assign wr_data    = data_reg;
  assign wr_en      = en_reg;
  assign can_accept = (en_reg == 4'b0) || wr_ready;

endmodule

// File: rtl/axis_mem_loader.sv
// AXI-Stream packet to data-memory burst writer (header beat + data beats).
// Optional AXIS_LOADER_BOUNDS_CHECK_EN: drop and flag writes at addr >= MEM_DEPTH.
module axis_mem_loader
  import gpu_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              axis_clk,
  input  logic              axis_aresetn,
  axis_mem_loader_if.slave  bus,
  output logic              pkt_done,
  output logic [ADDR_W:0]   pkt_words,
  output logic              err_header,
  output logic              err_bounds
);

`ifdef AXIS_LOADER_BOUNDS_CHECK_EN
  localparam int PTR_W = ADDR_W + 1;
`else
  localparam int PTR_W = ADDR_W;
`endif
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]  CNT_ONE = 1;

  loader_state_t     state_reg, state_next;
  logic [PTR_W-1:0]  addr_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   pkt_words_reg;
  logic              err_header_reg;
  logic              live_reg;
  logic              tready, beat, hdr_ok, in_range;
  logic              slot_load, slot_can_accept, slot_empty, done_pulse;

  assign beat       = bus.axis_tvalid && tready;
  assign hdr_ok     = (hdr_opcode(bus.axis_tdata) == OPC_WRITE);
  assign slot_empty = (bus.mem_wr_en == 4'b0);

`ifdef AXIS_LOADER_BOUNDS_CHECK_EN
  assign in_range = (addr_reg < PTR_W'(MEM_DEPTH));
`else
  assign in_range = 1'b1;
`endif

  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) state_reg <= HDR;
    else               state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    tready     = 1'b0;
    slot_load  = 1'b0;
    done_pulse = 1'b0;
    case (state_reg)
      HDR: begin
        tready = live_reg;
        if (beat) begin
          if (hdr_ok)                 state_next = bus.axis_tlast ? DONE : DATA;
          else if (!bus.axis_tlast)   state_next = DISCARD;
        end
      end
      DATA: begin
        tready = live_reg && slot_can_accept;
        if (beat) begin
          slot_load = in_range;
          if (bus.axis_tlast) state_next = DONE;
        end
      end
      DISCARD: begin
        tready = live_reg;
        if (beat && bus.axis_tlast) state_next = HDR;
      end
      DONE: begin
        if (slot_empty) begin
          done_pulse = 1'b1;
          state_next = HDR;
        end
      end
      default: state_next = HDR;
    endcase
  end

  // live_reg keeps tready low during the reset cycle itself.
  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      live_reg       <= 1'b0;
      addr_reg       <= '0;
      cnt_reg        <= '0;
      pkt_words_reg  <= '0;
      err_header_reg <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      if (beat) begin
        case (state_reg)
          HDR: begin
            if (hdr_ok) begin
              addr_reg <= PTR_W'(bus.axis_tdata[ADDR_W-1:0]);
              cnt_reg  <= '0;
              if (bus.axis_tlast) pkt_words_reg <= '0;
            end else begin
              err_header_reg <= 1'b1;
            end
          end
          DATA: begin
`ifdef AXIS_LOADER_BOUNDS_CHECK_EN
            addr_reg <= (&addr_reg) ? addr_reg : addr_reg + PTR_ONE;
`else
            addr_reg <= addr_reg + PTR_ONE;
`endif
            cnt_reg <= cnt_reg + CNT_ONE;
            if (bus.axis_tlast) pkt_words_reg <= cnt_reg + CNT_ONE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef AXIS_LOADER_BOUNDS_CHECK_EN
  logic err_bounds_reg;
  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn)                           err_bounds_reg <= 1'b0;
    else if (beat && state_reg == DATA && !in_range) err_bounds_reg <= 1'b1;
  end
  assign err_bounds = err_bounds_reg;
`else
  assign err_bounds = 1'b0;
`endif

  axis_wr_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk        (axis_clk),
    .rst_n      (axis_aresetn),
    .load       (slot_load),
    .load_addr  (addr_reg[ADDR_W-1:0]),
    .load_data  (bus.axis_tdata),
    .load_keep  (bus.axis_tkeep),
    .wr_ready   (bus.mem_wr_ready),
    .addr       (bus.mem_addr),
    .wr_data    (bus.mem_wr_data),
    .wr_en      (bus.mem_wr_en),
    .can_accept (slot_can_accept)
  );

  assign bus.axis_tready = tready;
  assign pkt_done        = done_pulse;
  assign pkt_words       = pkt_words_reg;
  assign err_header      = err_header_reg;

endmodule

// File: tb/tb_axis_mem_loader.sv
// Randomized bench for axis_mem_loader: a packet-level model predicts the write
// list, pkt_words and sticky errors; a negedge monitor compares retired writes.
`timescale 1ns/1ps
module tb_axis_mem_loader;
  localparam int ADDR_W    = 12;
  localparam int MEM_DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  logic              pkt_done;
  logic [ADDR_W:0]   pkt_words;
  logic              err_header, err_bounds;

  axis_mem_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .axis_clk     (clk),
    .axis_aresetn (rst_n),
    .bus          (bus),
    .pkt_done     (pkt_done),
    .pkt_words    (pkt_words),
    .err_header   (err_header),
    .err_bounds   (err_bounds)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        keep;
  } wr_t;

  int          n_vec = 0;
  int          n_err = 0;
  wr_t         exp_wr[$];
  int          exp_done[$];
  int          wr_cyc[$];
  bit          exp_err_header = 1'b0;
  bit          exp_err_bounds = 1'b0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          hold_left = 0;
  int          hold_seen = 0;
  bit          in_hold = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [31:0] hold_data = '0;
  logic [31:0] pkt_data[16];
  logic [3:0]  pkt_keep[16];
  wr_t         mon_wr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory-side ready: stalls a chosen address for hold_left cycles, otherwise by mode.
  initial begin
    bus.mem_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_left > 0 && bus.mem_wr_en != 4'b0 && bus.mem_addr == hold_addr) begin
        bus.mem_wr_ready = 1'b0;
        in_hold = 1'b1;
        hold_left--;
        hold_seen++;
      end else begin
        in_hold = 1'b0;
        bus.mem_wr_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_wr_en != 4'b0 && bus.mem_wr_ready) begin
        mon_wr = {bus.mem_addr, bus.mem_wr_data, bus.mem_wr_en};
        if (exp_wr.size() == 0) check_val("unexpected_wr", mon_wr, '0);
        else begin
          check_val("wr", mon_wr, exp_wr.pop_front());
          wr_cyc.push_back(cyc);
        end
      end
      if (in_hold) begin
        check_val("hold_addr", bus.mem_addr, hold_addr);
        check_val("hold_data", bus.mem_wr_data, hold_data);
        check_val("hold_tready", bus.axis_tready, 1'b0);
      end
      if (pkt_done) begin
        if (exp_done.size() == 0) check_val("spurious_done", pkt_done, 1'b0);
        else                      check_val("pkt_words", pkt_words, exp_done.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit last, input bit gaps);
    int waits;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.axis_tdata  = d;
    bus.axis_tkeep  = k;
    bus.axis_tlast  = last;
    bus.axis_tvalid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.axis_tready) break;
      waits++;
      if (waits > 200) begin
        check_val("tready_timeout", bus.axis_tready, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.axis_tvalid = 1'b0;
    bus.axis_tdata  = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) check_val("drain_timeout", 64'(exp_wr.size() + exp_done.size()), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("err_header", err_header, exp_err_header);
    check_val("err_bounds", err_bounds, exp_err_bounds);
  endtask

  // Packet model: data beat i lands at start+i; keep==0 beats write nothing.
  task automatic run_packet(input logic [31:0] hdr, input int n, input bit gaps);
    int  a;
    wr_t w;
    if (hdr[31:28] == 4'hA) begin
      for (int i = 0; i < n; i++) begin
        a = int'(hdr[ADDR_W-1:0]) + i;
`ifdef AXIS_LOADER_BOUNDS_CHECK_EN
        if (a >= MEM_DEPTH) begin
          exp_err_bounds = 1'b1;
          continue;
        end
`endif
        if (pkt_keep[i] != 4'h0) begin
          w.addr = ADDR_W'(a % (1 << ADDR_W));
          w.data = pkt_data[i];
          w.keep = pkt_keep[i];
          exp_wr.push_back(w);
        end
      end
      exp_done.push_back(n);
    end else begin
      exp_err_header = 1'b1;
    end
    send_beat(hdr, 4'hF, n == 0, gaps);
    for (int i = 0; i < n; i++) send_beat(pkt_data[i], pkt_keep[i], i == n - 1, gaps);
    drain();
  endtask

  task automatic set_beats(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2);
    pkt_data[0] = d0; pkt_data[1] = d1; pkt_data[2] = d2;
    pkt_keep[0] = k0; pkt_keep[1] = k1; pkt_keep[2] = k2;
  endtask

  initial begin
    logic [31:0] hdr;
    logic [3:0]  opc;
    int          n;
    bus.axis_tvalid = 1'b0;
    bus.axis_tdata  = '0;
    bus.axis_tkeep  = '0;
    bus.axis_tlast  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_tready", bus.axis_tready, 1'b0);
    check_val("rst_wr_en", bus.mem_wr_en, 4'h0);
    check_val("rst_addr", bus.mem_addr, '0);
    check_val("rst_data", bus.mem_wr_data, '0);
    check_val("rst_pkt_done", pkt_done, 1'b0);
    check_val("rst_pkt_words", pkt_words, '0);
    check_val("rst_err_header", err_header, 1'b0);
    check_val("rst_err_bounds", err_bounds, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("tready_hdr", bus.axis_tready, 1'b1);
    @(posedge clk);
    #1;

    // Full-throughput burst: writes on consecutive cycles.
    set_beats(32'h11, 32'h22, 32'h33, 4'hF, 4'hF, 4'hF);
    wr_cyc.delete();
    run_packet(32'hA000_0010, 3, 1'b0);
    check_val("t1_nwr", 64'(wr_cyc.size()), 3);
    if (wr_cyc.size() == 3) begin
      check_val("t1_gap01", 64'(wr_cyc[1] - wr_cyc[0]), 1);
      check_val("t1_gap12", 64'(wr_cyc[2] - wr_cyc[1]), 1);
    end

    // Five-cycle stall on the second write.
    hold_addr = 12'h011; hold_data = 32'h22; hold_left = 5; hold_seen = 0;
    run_packet(32'hA000_0010, 3, 1'b0);
    check_val("t2_hold_cycles", 64'(hold_seen), 5);

    // Bad opcode is discarded, next packet unaffected.
    set_beats(32'hDEAD_0001, 32'hDEAD_0002, 32'h0, 4'hF, 4'hF, 4'hF);
    run_packet(32'h5000_0000, 2, 1'b0);
    set_beats(32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'h3, 4'hC, 4'hF);
    run_packet(32'hA000_0100, 2, 1'b0);

    // Top-of-memory boundary.
    set_beats(32'hAAAA_0FFF, 32'hBBBB_0000, 32'h0, 4'hF, 4'hF, 4'hF);
    run_packet(32'hA000_0FFF, 2, 1'b0);

    // Zero-length packet, then a keep==0 hole in the middle of a burst.
    run_packet(32'hA000_0020, 0, 1'b0);
    set_beats(32'h40, 32'h41, 32'h42, 4'hF, 4'h0, 4'hF);
    run_packet(32'hA000_0040, 3, 1'b0);

    // Randomized packets with random backpressure and valid gaps.
    ready_mode = 1;
    for (int p = 0; p < 30; p++) begin
      opc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hA;
      hdr = {opc, 16'($urandom), 12'($urandom)};
      if ($urandom_range(0, 4) == 0) hdr[11:0] = 12'(4095 - $urandom_range(0, 3));
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        pkt_data[i] = $urandom;
        pkt_keep[i] = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      run_packet(hdr, n, 1'b1);
    end

    // Reset while a write is stalled in the output register.
    ready_mode = 0;
    hold_addr = 12'h300; hold_data = 32'hCAFE_0001; hold_left = 1000;
    send_beat(32'hA000_0300, 4'hF, 1'b0, 1'b0);
    send_beat(32'hCAFE_0001, 4'hF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("t6_pending_en", bus.mem_wr_en, 4'hF);
    @(posedge clk);
    #1 rst_n = 1'b0;
    hold_left = 0;
    exp_err_header = 1'b0;
    exp_err_bounds = 1'b0;
    @(negedge clk);
    check_val("mrst_tready", bus.axis_tready, 1'b0);
    check_val("mrst_wr_en", bus.mem_wr_en, 4'h0);
    check_val("mrst_addr", bus.mem_addr, '0);
    check_val("mrst_data", bus.mem_wr_data, '0);
    check_val("mrst_pkt_done", pkt_done, 1'b0);
    check_val("mrst_pkt_words", pkt_words, '0);
    check_val("mrst_err_header", err_header, 1'b0);
    check_val("mrst_err_bounds", err_bounds, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_beats(32'h5050_0001, 32'h5050_0002, 32'h0, 4'hF, 4'h5, 4'hF);
    run_packet(32'hA000_0050, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
